// File: rtl/ir_receiver.sv
// NEC infrared frame decoder: measures mark/space widths in nec_clk ticks and
// publishes the last 32-bit frame whose address and command bytes pass their complement check.
module ir_receiver #(
    parameter int unsigned LEAD_MIN  = 128,
    parameter int unsigned LEAD_MAX  = 192,
    parameter int unsigned SPACE_MIN = 64,
    parameter int unsigned SPACE_MAX = 96,
    parameter int unsigned UNIT_MIN  = 5,
    parameter int unsigned UNIT_MAX  = 15,
    parameter int unsigned ONE_MIN   = 20,
    parameter int unsigned ONE_MAX   = 40
) (
    input  logic        nec_clk,
    input  logic        reset_n,
    input  logic        ir_signal,
    output logic [31:0] word
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LEAD_MARK  = 3'd1;
    localparam logic [2:0] LEAD_SPACE = 3'd2;
    localparam logic [2:0] BIT_MARK   = 3'd3;
    localparam logic [2:0] BIT_SPACE  = 3'd4;

    localparam logic [7:0] L_LEAD_MIN  = LEAD_MIN[7:0];
    localparam logic [7:0] L_LEAD_MAX  = LEAD_MAX[7:0];
    localparam logic [7:0] L_SPACE_MIN = SPACE_MIN[7:0];
    localparam logic [7:0] L_SPACE_MAX = SPACE_MAX[7:0];
    localparam logic [7:0] L_UNIT_MIN  = UNIT_MIN[7:0];
    localparam logic [7:0] L_UNIT_MAX  = UNIT_MAX[7:0];
    localparam logic [7:0] L_ONE_MIN   = ONE_MIN[7:0];
    localparam logic [7:0] L_ONE_MAX   = ONE_MAX[7:0];

    logic        r_sync1, r_sync2, r_prev;
    logic [7:0]  r_cnt;
    logic [2:0]  r_state, w_state_nxt;
    logic [31:0] r_sr, w_sr_nxt;
    logic [5:0]  r_bits, w_bits_nxt;
    logic [31:0] r_word, w_word_nxt;
    logic        w_fall, w_rise, w_sat;

    function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    assign w_fall = r_prev & ~r_sync2;
    assign w_rise = ~r_prev & r_sync2;
    assign w_sat  = (r_cnt == 8'hFF);
    assign word   = r_word;

    always_ff @(posedge nec_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= IDLE;
            r_sr    <= 32'd0;
            r_bits  <= 6'd0;
            r_word  <= 32'd0;
        end else begin
            r_sync1 <= ir_signal;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_fall || w_rise) begin
                r_cnt <= 8'd0;
            end else if (!w_sat) begin
                r_cnt <= r_cnt + 8'd1;
            end
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_bits  <= w_bits_nxt;
            r_word  <= w_word_nxt;
        end
    end

    // r_cnt holds the width of the level that just ended while an edge is flagged.
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_bits_nxt  = r_bits;
        w_word_nxt  = r_word;
        case (r_state)
            IDLE: begin
                if (w_fall) w_state_nxt = LEAD_MARK;
            end
            LEAD_MARK: begin
                if (w_rise) begin
                    w_state_nxt = in_range(r_cnt, L_LEAD_MIN, L_LEAD_MAX) ? LEAD_SPACE : IDLE;
                end else if (w_sat) begin
                    w_state_nxt = IDLE;
                end
            end
            LEAD_SPACE: begin
                if (w_fall) begin
                    if (in_range(r_cnt, L_SPACE_MIN, L_SPACE_MAX)) begin
                        w_state_nxt = BIT_MARK;
                        w_sr_nxt    = 32'd0;
                        w_bits_nxt  = 6'd0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_sat) begin
                    w_state_nxt = IDLE;
                end
            end
            BIT_MARK: begin
                if (w_rise) begin
                    if (!in_range(r_cnt, L_UNIT_MIN, L_UNIT_MAX)) begin
                        w_state_nxt = IDLE;
                    end else if (r_bits == 6'd32) begin
                        // Stop mark: accept only if both bytes match their complements.
                        if ((r_sr[31:24] == ~r_sr[23:16]) && (r_sr[15:8] == ~r_sr[7:0])) begin
                            w_word_nxt = r_sr;
                        end
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = BIT_SPACE;
                    end
                end else if (w_sat) begin
                    w_state_nxt = IDLE;
                end
            end
            BIT_SPACE: begin
                if (w_fall) begin
                    if (in_range(r_cnt, L_UNIT_MIN, L_UNIT_MAX)) begin
                        w_sr_nxt    = {r_sr[30:0], 1'b0};
                        w_bits_nxt  = r_bits + 6'd1;
                        w_state_nxt = BIT_MARK;
                    end else if (in_range(r_cnt, L_ONE_MIN, L_ONE_MAX)) begin
                        w_sr_nxt    = {r_sr[30:0], 1'b1};
                        w_bits_nxt  = r_bits + 6'd1;
                        w_state_nxt = BIT_MARK;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_sat) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ir_receiver.sv
// Self-checking bench for ir_receiver: directed NEC scenarios plus randomized frames
// scored against a duration-level frame model.
`timescale 1ns/1ps
module tb_ir_receiver;

    localparam int unsigned LEAD_MIN  = 128;
    localparam int unsigned LEAD_MAX  = 192;
    localparam int unsigned SPACE_MIN = 64;
    localparam int unsigned SPACE_MAX = 96;
    localparam int unsigned UNIT_MIN  = 5;
    localparam int unsigned UNIT_MAX  = 15;
    localparam int unsigned ONE_MIN   = 20;
    localparam int unsigned ONE_MAX   = 40;
    localparam int          IDLE_GAP  = 89;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ir;
    logic [31:0] word;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_word  = 32'h0;
    logic [31:0] pend_word = 32'h0;
    int          pend_cnt  = 0;
    bit          chk_en    = 1'b0;
    int          q[$];

    always #5 clk = ~clk;

    ir_receiver #(
        .LEAD_MIN (LEAD_MIN),
        .LEAD_MAX (LEAD_MAX),
        .SPACE_MIN(SPACE_MIN),
        .SPACE_MAX(SPACE_MAX),
        .UNIT_MIN (UNIT_MIN),
        .UNIT_MAX (UNIT_MAX),
        .ONE_MIN  (ONE_MIN),
        .ONE_MAX  (ONE_MAX)
    ) dut (
        .nec_clk  (clk),
        .reset_n  (reset_n),
        .ir_signal(ir),
        .word     (word)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Leaves the caller 1 ns after the n-th following rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit inr(input int v, input int unsigned lo, input int unsigned hi);
        return (v >= int'(lo)) && (v <= int'(hi));
    endfunction

    // Frame model over q: [lead low, lead high, {mark, space} x32, stop mark].
    function automatic bit model_decode(output logic [31:0] code);
        code = 32'h0;
        if (q.size() != 67) return 1'b0;
        if (!inr(q[0], LEAD_MIN, LEAD_MAX) || !inr(q[1], SPACE_MIN, SPACE_MAX)) return 1'b0;
        for (int b = 0; b < 32; b++) begin
            if (!inr(q[2 + 2 * b], UNIT_MIN, UNIT_MAX)) return 1'b0;
            if (inr(q[3 + 2 * b], UNIT_MIN, UNIT_MAX)) code[31 - b] = 1'b0;
            else if (inr(q[3 + 2 * b], ONE_MIN, ONE_MAX)) code[31 - b] = 1'b1;
            else return 1'b0;
        end
        if (!inr(q[66], UNIT_MIN, UNIT_MAX)) return 1'b0;
        return (code[31:24] == ~code[23:16]) && (code[15:8] == ~code[7:0]);
    endfunction

    task automatic build_frame(input logic [31:0] code, input int lead_lo, input int lead_hi,
                               input bit jit);
        q.delete();
        q.push_back(lead_lo);
        q.push_back(lead_hi);
        for (int b = 0; b < 32; b++) begin
            q.push_back(jit ? int'($urandom_range(8, 13)) : 10);
            if (code[31 - b]) q.push_back(jit ? int'($urandom_range(24, 37)) : 30);
            else              q.push_back(jit ? int'($urandom_range(8, 13)) : 10);
        end
        q.push_back(jit ? int'($urandom_range(8, 13)) : 10);
    endtask

    // Drives q (even = low, odd = high), returns the line high and posts the model's verdict.
    task automatic play();
        logic [31:0] code;
        bit          ok;
        ok = model_decode(code);
        for (int i = 0; i < q.size(); i++) begin
            ir = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(q[i]);
        end
        ir = 1'b1;
        if (ok) begin
            pend_word = code;
            pend_cnt  = 5;
        end
    endtask

    task automatic frame(input logic [31:0] code, input int lead_lo, input int lead_hi,
                         input bit jit);
        build_frame(code, lead_lo, lead_hi, jit);
        play();
        step(IDLE_GAP + (jit ? int'($urandom_range(0, 20)) : 0));
    endtask

    // Per-cycle comparison of word against the model's expected value.
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (pend_cnt > 0) begin
                if (word === pend_word) begin
                    exp_word = pend_word;
                    pend_cnt = 0;
                end else if (word !== exp_word) begin
                    n_fail++;
                    $display("FAIL word_transient: got %h, required %h or %h",
                             word, exp_word, pend_word);
                end else begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        n_fail++;
                        $display("FAIL word_update_late: got %h, required %h", word, pend_word);
                    end
                end
            end else if (word !== exp_word) begin
                n_fail++;
                $display("FAIL word_stable: got %h, required %h", word, exp_word);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  addr, cmd;
        logic [31:0] code;
        int          lead;

        reset_n = 1'b0;
        ir      = 1'b1;
        #1;
        chk_en  = 1'b1;
        step(10);
        check32("reset_word", word, 32'h0);
        reset_n = 1'b1;
        step(IDLE_GAP);
        check32("idle_word", word, 32'h0);

        frame(32'h20DF6A95, 160, 80, 1'b0);
        check32("frame_6a95", word, 32'h20DF6A95);
        frame(32'h20DFEA15, 160, 80, 1'b0);
        check32("frame_ea15", word, 32'h20DFEA15);
        frame(32'h20DF1AE5, 160, 80, 1'b0);
        check32("frame_1ae5", word, 32'h20DF1AE5);
        frame(32'h20DF9A65, 160, 80, 1'b0);
        check32("frame_9a65", word, 32'h20DF9A65);

        frame(32'h20DF6A94, 160, 80, 1'b0);
        check32("corrupt_cmd", word, 32'h20DF9A65);

        frame(32'h20DF6A95, 71, 80, 1'b0);
        check32("short_leader", word, 32'h20DF9A65);

        q = '{160, 40, 10};
        play();
        step(IDLE_GAP);
        check32("repeat_code", word, 32'h20DF9A65);

        frame(32'h20DFEA15, 160, 80, 1'b0);
        check32("after_repeat", word, 32'h20DFEA15);

        // Leader then a line left high long enough to saturate the counter.
        q = '{160, 80};
        play();
        step(300);
        frame(32'h20DF1AE5, 160, 80, 1'b0);
        check32("after_timeout", word, 32'h20DF1AE5);

        // Reset after 10 data bits.
        build_frame(32'h20DF6A95, 160, 80, 1'b0);
        for (int i = 0; i < 22; i++) begin
            ir = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(q[i]);
        end
        exp_word = 32'h0;
        pend_cnt = 0;
        reset_n  = 1'b0;
        ir       = 1'b1;
        step(3);
        check32("reset_mid_frame", word, 32'h0);
        reset_n = 1'b1;
        step(IDLE_GAP);
        frame(32'h20DF6A95, 160, 80, 1'b0);
        check32("after_reset", word, 32'h20DF6A95);

        for (int n = 0; n < 25; n++) begin
            addr = 8'($urandom);
            cmd  = 8'($urandom);
            code = {addr, ~addr, cmd, ~cmd};
            if ($urandom_range(0, 3) == 0) code[$urandom_range(0, 31)] ^= 1'b1;
            lead = ($urandom_range(0, 7) == 0) ? 71 : int'($urandom_range(150, 170));
            frame(code, lead, int'($urandom_range(72, 88)), 1'b1);
        end

        step(10);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
